// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Pipeline stall/flush controller for a fetch/decode/execute pipeline.
//   Turns load-use, pop-then-jump and taken-branch requests into PC write
//   enable, IF/ID write enable, IF/ID flush and ID/EX bubble controls.
//   Outputs are decoded combinationally from the state and the live requests,
//   so a hazard stalls the pipe in the same cycle it is raised.
//
//   Optional build feature:
//     STALL_CNT_EN - adds the 16-bit saturating stall_cycles counter and port.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned LU_CYCLES     = 1,
    parameter int unsigned POPJMP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_req,
    input  logic        popjmp_req,
    input  logic        flush_req,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        stall_active
`ifdef STALL_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    // Bubble lengths narrowed to the width of the remaining-cycle counter.
    localparam logic [2:0] LU_LEN     = 3'(LU_CYCLES);
    localparam logic [2:0] POPJMP_LEN = 3'(POPJMP_CYCLES);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  rem_q;
    logic [2:0]  rem_d;

    // State used for output decoding: reset forces RUN decoding.
    state_t      dec_state_s;
    // Bubble length of the hazard raised this cycle (popjmp wins over lu).
    logic [2:0]  hz_len_s;
    logic        hz_req_s;

    // Remaining stall cycles after the request cycle has been spent.
    function automatic logic [2:0] rem_after_first(input logic [2:0] len);
        logic [2:0] r;
        if (len > 3'd1) begin
            r = len - 3'd1;
        end else begin
            r = 3'd0;
        end
        return r;
    endfunction

    // Select decoding state and the length of any newly raised hazard.
    always_comb begin
        dec_state_s = ST_RUN;
        hz_len_s    = LU_LEN;
        hz_req_s    = 1'b0;
        if (rst) begin
            dec_state_s = state_q;
        end else begin
            dec_state_s = ST_RUN;
        end
        if (popjmp_req) begin
            hz_len_s = POPJMP_LEN;
            hz_req_s = 1'b1;
        end else if (lu_req) begin
            hz_len_s = LU_LEN;
            hz_req_s = 1'b1;
        end else begin
            hz_len_s = LU_LEN;
            hz_req_s = 1'b0;
        end
    end

    // Next-state and pipeline control decode.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        stall_active = 1'b0;
        case (dec_state_s)
            ST_RUN: begin
                if (flush_req) begin
                    // Taken branch: squash the wrong-path fetch, keep PC moving.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                    rem_d       = 3'd0;
                end else if (hz_req_s) begin
                    // First bubble is issued in the request cycle itself.
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_bubble  = 1'b1;
                    stall_active = 1'b1;
                    rem_d        = rem_after_first(hz_len_s);
                    if (hz_len_s > 3'd1) begin
                        state_d = ST_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                    rem_d   = 3'd0;
                end
            end
            ST_STALL: begin
                stall_active = 1'b1;
                if (flush_req) begin
                    // A resolved branch makes the stalled instruction dead.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                    rem_d       = 3'd0;
                end else begin
                    // New hazard requests are ignored; decode re-raises later.
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    if (rem_q <= 3'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 3'd0;
                    end else begin
                        state_d = ST_STALL;
                        rem_d   = rem_q - 3'd1;
                    end
                end
            end
            default: begin
                // Unreachable encoding: recover to RUN without bubbles.
                state_d = ST_RUN;
                rem_d   = 3'd0;
            end
        endcase
    end

    // FSM state and remaining-cycle register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    // Saturating count of cycles in which fetch was frozen.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_we && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Self-checking bench for hazard_stall_ctrl (LU_CYCLES=1, POPJMP_CYCLES=2).
//   Each cycle's inputs and expected outputs are pushed to a scoreboard queue;
//   the entry is popped and compared at the following falling edge.
//   Counter checks are compiled in only when STALL_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        lu_req;
    logic        popjmp_req;
    logic        flush_req;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        stall_active;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks;
    int errors;

    // Output vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active}
    localparam logic [4:0] RUNO = 5'b11000;
    localparam logic [4:0] BUB  = 5'b00011;
    localparam logic [4:0] FLR  = 5'b11110;
    localparam logic [4:0] ALL  = 5'b11111;
    localparam logic [4:0] NOSA = 5'b11110;

    typedef struct packed {
        logic        r;
        logic        l;
        logic        p;
        logic        f;
        logic [4:0]  o;
        logic [4:0]  m;
        logic        cc;
        logic [15:0] cv;
    } step_t;

    step_t sb[$];

    hazard_stall_ctrl #(
        .LU_CYCLES    (1),
        .POPJMP_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lu_req      (lu_req),
        .popjmp_req  (popjmp_req),
        .flush_req   (flush_req),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .stall_active(stall_active)
`ifdef STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs and record what the DUT must show.
    task automatic drive(input step_t s);
        rst        = s.r;
        lu_req     = s.l;
        popjmp_req = s.p;
        flush_req  = s.f;
        sb.push_back(s);
    endtask

    task automatic test_reset;
        step_t st[5];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd0};
        st[2] = '{1'b0, 1'b1, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd0};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd0};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd0};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL reset step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL reset step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use;
        step_t st[4];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b1, 1'b1, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd0};
        st[2] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd1};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd1};
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL load_use step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL load_use step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_popjmp;
        step_t st[5];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b1, 1'b0, 1'b1, 1'b0, BUB,  ALL, 1'b1, 16'd0};
        st[2] = '{1'b1, 1'b0, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd1};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd2};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd2};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL popjmp step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL popjmp step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush;
        step_t st[7];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL,  1'b0, 16'd0};
        st[1] = '{1'b1, 1'b0, 1'b0, 1'b1, FLR,  ALL,  1'b1, 16'd0};
        st[2] = '{1'b1, 1'b1, 1'b1, 1'b1, FLR,  ALL,  1'b1, 16'd0};
        st[3] = '{1'b1, 1'b0, 1'b1, 1'b0, BUB,  ALL,  1'b1, 16'd0};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b1, FLR,  NOSA, 1'b1, 16'd1};
        st[5] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL,  1'b1, 16'd1};
        st[6] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL,  1'b1, 16'd1};
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL flush step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL flush step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_both_requests;
        step_t st[5];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b1, 1'b1, 1'b1, 1'b0, BUB,  ALL, 1'b1, 16'd0};
        st[2] = '{1'b1, 1'b1, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd1};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd2};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd2};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL both_req step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL both_req step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_stall;
        step_t st[5];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b1, 1'b0, 1'b1, 1'b0, BUB,  ALL, 1'b1, 16'd0};
        st[2] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd1};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd0};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd0};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL rst_mid_stall step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL rst_mid_stall step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back;
        step_t st[6];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b1, 1'b1, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd0};
        st[2] = '{1'b1, 1'b0, 1'b1, 1'b0, BUB,  ALL, 1'b1, 16'd1};
        st[3] = '{1'b1, 1'b1, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd2};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'd3};
        st[5] = '{1'b1, 1'b1, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'd3};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL back_to_back step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
`ifdef STALL_CNT_EN
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL back_to_back step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

`ifdef STALL_CNT_EN
    task automatic test_saturate;
        step_t st[5];
        step_t e;
        logic [4:0] obs;
        st[0] = '{1'b0, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b0, 16'd0};
        st[1] = '{1'b1, 1'b0, 1'b1, 1'b0, BUB,  ALL, 1'b1, 16'hFFFE};
        st[2] = '{1'b1, 1'b0, 1'b0, 1'b0, BUB,  ALL, 1'b1, 16'hFFFF};
        st[3] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'hFFFF};
        st[4] = '{1'b1, 1'b0, 1'b0, 1'b0, RUNO, ALL, 1'b1, 16'hFFFF};
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                dut.stall_cycles_q = 16'hFFFE;
            end
            drive(st[i]);
            @(negedge clk);
            e   = sb.pop_front();
            obs = {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active};
            checks++;
            if ((obs & e.m) !== (e.o & e.m)) begin
                errors++;
                $display("FAIL saturate step %0d outputs got %b want %b mask %b", i, obs, e.o, e.m);
            end
            if (e.cc) begin
                checks++;
                if (stall_cycles !== e.cv) begin
                    errors++;
                    $display("FAIL saturate step %0d stall_cycles got %h want %h", i, stall_cycles, e.cv);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        lu_req     = 1'b0;
        popjmp_req = 1'b0;
        flush_req  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_popjmp();
        test_flush();
        test_both_requests();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef STALL_CNT_EN
        test_saturate();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
